// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multicycle CPU core: opcodes, function codes, FSM states, ALU ops.
package mc_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  // HALT is decoded separately, so it is not counted as legal here.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic alu_op_t alu_decode(input logic [5:0] op, input logic [5:0] fn);
    alu_op_t sel;
    sel = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  sel = ALU_SUB;
        FN_AND:  sel = ALU_AND;
        FN_OR:   sel = ALU_OR;
        FN_SLT:  sel = ALU_SLT;
        default: sel = ALU_ADD;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mc_regbank.sv
// Register bank: NUM_REGS x 32, two async read ports, one sync write port, R0 reads 0.
// Latency: reads combinational, write visible the cycle after we.
// Backpressure: none; a write is taken whenever we=1.
module mc_regbank #(
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_REGS)-1:0] ra1,
  output logic [31:0]                 rd1,
  input  logic [$clog2(NUM_REGS)-1:0] ra2,
  output logic [31:0]                 rd2,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] wa,
  input  logic [31:0]                 wd
);

  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mc_cpu_core.sv
// Multicycle MIPS-subset core on one shared req/ready memory port; OVERFLOW_TRAP_EN adds overflow traps to EXC_VEC.
// Latency: R/addi 4, lw 5, sw 4, beq/bne/j 3 cycles at zero wait.
// Backpressure: FETCH and MEM hold req/addr/we/wdata stable and stall until mem_ready.
module mc_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                NUM_REGS = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       EXC_VEC  = 32'h80
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_dbg
);

  localparam int RW = $clog2(NUM_REGS);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir, mdr, a, b, alu_out;
  logic              illegal_q;

  logic [5:0]    op, fn;
  logic [31:0]   imm_sext, pc_ext, jmp_tgt, opb, alu_res, rs_dat, rt_dat, wb_dat;
  logic [RW-1:0] wb_idx;
  logic          legal, rf_we;
  alu_op_t       alu_op;

  assign op       = ir[31:26];
  assign fn       = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign pc_ext   = 32'(pc);
  assign jmp_tgt  = {pc_ext[31:28], ir[25:0], 2'b00};
  assign legal    = is_legal(op, fn);
  assign alu_op   = alu_decode(op, fn);
  assign opb      = (op == OP_RTYPE) ? b : imm_sext;

  always_comb begin
    alu_res = a + opb;
    case (alu_op)
      ALU_SUB: alu_res = a - opb;
      ALU_AND: alu_res = a & opb;
      ALU_OR:  alu_res = a | opb;
      ALU_SLT: alu_res = {31'd0, $signed(a) < $signed(opb)};
      default: alu_res = a + opb;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic              alu_ovf, ovf_q;
  logic [ADDR_W-1:0] epc;
  logic              unused_epc;

  always_comb begin
    alu_ovf = 1'b0;
    if (alu_op == ALU_ADD)      alu_ovf = (a[31] == opb[31]) && (alu_res[31] != a[31]);
    else if (alu_op == ALU_SUB) alu_ovf = (a[31] != opb[31]) && (alu_res[31] != a[31]);
  end

  // Overflow is latched in EXEC and acted on in WB, so a trap costs the same 4 cycles as a normal op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      epc   <= '0;
    end else begin
      if (state == EXEC) ovf_q <= alu_ovf && ((op == OP_RTYPE) || (op == OP_ADDI));
      if ((state == WB) && ovf_q) epc <= pc - ADDR_W'(4);
    end
  end

  assign unused_epc = ^epc;
  assign rf_we      = (state == WB) && !ovf_q;
`else
  logic unused_exc;
  assign unused_exc = ^EXC_VEC;
  assign rf_we      = (state == WB);
`endif

  assign wb_idx = (op == OP_RTYPE) ? ir[11 +: RW] : ir[16 +: RW];
  assign wb_dat = (op == OP_LW) ? mdr : alu_out;

  mc_regbank #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (ir[21 +: RW]),
    .rd1   (rs_dat),
    .ra2   (ir[16 +: RW]),
    .rd2   (rt_dat),
    .we    (rf_we),
    .wa    (wb_idx),
    .wd    (wb_dat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  if (mem_ready) state_nxt = DECODE;
      DECODE: state_nxt = ((op == OP_HALT) || !legal) ? HALT : EXEC;
      EXEC: begin
        case (op)
          OP_RTYPE, OP_ADDI: state_nxt = WB;
          OP_LW, OP_SW:      state_nxt = MEM;
          default:           state_nxt = FETCH;
        endcase
      end
      MEM:     if (mem_ready) state_nxt = (op == OP_LW) ? WB : FETCH;
      WB:      state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      ir        <= '0;
      mdr       <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + ADDR_W'(4);
          end
        end
        DECODE: begin
          a       <= rs_dat;
          b       <= rt_dat;
          // pc already holds PC+4 here, so this is the branch target.
          alu_out <= pc_ext + {imm_sext[29:0], 2'b00};
          if ((op != OP_HALT) && !legal) illegal_q <= 1'b1;
        end
        EXEC: begin
          case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW: alu_out <= alu_res;
            OP_BEQ:  if (a == b) pc <= alu_out[ADDR_W-1:0];
            OP_BNE:  if (a != b) pc <= alu_out[ADDR_W-1:0];
            OP_J:    pc <= jmp_tgt[ADDR_W-1:0];
            default: ;
          endcase
        end
        MEM: begin
          if (mem_ready && (op == OP_LW)) mdr <= mem_rdata;
        end
        WB: begin
`ifdef OVERFLOW_TRAP_EN
          if (ovf_q) pc <= EXC_VEC[ADDR_W-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  // Reset drops the request combinationally so a pending transaction never completes.
  assign mem_req   = !reset && ((state == FETCH) || (state == MEM));
  assign mem_we    = (state == MEM) && (op == OP_SW);
  assign mem_addr  = {((state == MEM) ? alu_out[ADDR_W-1:2] : pc[ADDR_W-1:2]), 2'b00};
  assign mem_wdata = b;
  assign halted    = (state == HALT);
  assign illegal   = illegal_q;
  assign pc_dbg    = pc;

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: small programs in a wait-state memory model, checks via immediate assertions.
module tb_mc_cpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

  logic [31:0] mem [0:255];
  int          wait_n = 0;
  int          wait_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_dat = '0;
  logic [31:0] rd_log [$];
  int          stab_err = 0;
  logic        pend_q = 1'b0;
  logic        pend_we = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] pend_wd = '0;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  mc_cpu_core #(.ADDR_W(32), .NUM_REGS(32), .RESET_PC(32'h0), .EXC_VEC(32'h80)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .illegal   (illegal),
    .pc_dbg    (pc_dbg)
  );

  always #5 clk = ~clk;

  assign mem_ready = mem_req && (wait_cnt >= wait_n);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (!reset && mem_req && mem_ready) begin
      if (mem_we) begin
        mem[mem_addr[9:2]] = mem_wdata;
        wr_cnt++;
        wr_addr = mem_addr;
        wr_dat  = mem_wdata;
      end else begin
        rd_log.push_back(mem_addr);
      end
    end
    wait_cnt <= (reset || !mem_req || mem_ready) ? 0 : wait_cnt + 1;
  end

  // A stalled request must reappear unchanged on the next cycle.
  always @(negedge clk) begin
    if (!reset && pend_q &&
        !(mem_req && mem_addr == pend_addr && mem_we == pend_we && mem_wdata == pend_wd))
      stab_err++;
    pend_q    = !reset && mem_req && !mem_ready;
    pend_addr = mem_addr;
    pend_we   = mem_we;
    pend_wd   = mem_wdata;
  end

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic begin_reset();
    @(negedge clk);
    reset  = 1'b1;
    wait_n = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rd_log.delete();
    wr_cnt  = 0;
    wr_addr = '0;
    wr_dat  = '0;
  endtask

  task automatic end_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_halt(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!halted && n < max_cyc) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_pc", pc_dbg, 32'h0);

    // 1: straight-line arithmetic, halt at cycle 15
    begin_reset();
    mem[0] = enc_i(6'h08, 0, 1, 16'd5);
    mem[1] = enc_i(6'h08, 0, 2, 16'd7);
    mem[2] = enc_r(1, 2, 3, 6'h20);
    mem[3] = HALT_W;
    end_reset();
    edges(13);
    check("t1_not_yet_halted", {31'd0, halted}, 32'd0);
    edges(1);
    check("t1_halted", {31'd0, halted}, 32'd1);
    check("t1_illegal", {31'd0, illegal}, 32'd0);
    check("t1_r3", dut.u_rf.regs[3], 32'd12);
    check("t1_pc", pc_dbg, 32'h10);
    check("t1_no_req", {31'd0, mem_req}, 32'd0);

    // 2: sw/lw with 3 wait cycles per access
    begin_reset();
    wait_n = 3;
    mem[0] = enc_i(6'h08, 0, 3, 16'd12);
    mem[1] = enc_i(6'h2B, 0, 3, 16'h40);
    mem[2] = enc_i(6'h23, 0, 4, 16'h40);
    mem[3] = HALT_W;
    end_reset();
    edges(2);
    check("t2_fetch_stall_ready", {31'd0, mem_ready}, 32'd0);
    check("t2_fetch_stall_addr", mem_addr, 32'h0);
    edges(11);
    check("t2_sw_req", {31'd0, mem_req}, 32'd1);
    check("t2_sw_we", {31'd0, mem_we}, 32'd1);
    check("t2_sw_addr", mem_addr, 32'h40);
    check("t2_sw_wdata", mem_wdata, 32'd12);
    edges(2);
    check("t2_sw_wait_ready", {31'd0, mem_ready}, 32'd0);
    check("t2_sw_wait_addr", mem_addr, 32'h40);
    edges(17);
    check("t2_not_yet_halted", {31'd0, halted}, 32'd0);
    edges(1);
    check("t2_halted", {31'd0, halted}, 32'd1);
    check("t2_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t2_wr_addr", wr_addr, 32'h40);
    check("t2_wr_data", wr_dat, 32'd12);
    check("t2_mem_word", mem[16], 32'd12);
    check("t2_r4", dut.u_rf.regs[4], 32'd12);
    check("t2_req_stable", 32'(stab_err), 32'd0);

    // 3a: taken beq then j
    begin_reset();
    mem[0] = enc_i(6'h08, 0, 1, 16'd5);
    mem[1] = enc_i(6'h04, 1, 1, 16'd2);
    mem[2] = enc_i(6'h08, 0, 6, 16'd1);
    mem[3] = enc_i(6'h08, 0, 6, 16'd2);
    mem[4] = {6'h02, 26'd6};
    mem[5] = enc_i(6'h08, 0, 6, 16'd3);
    mem[6] = HALT_W;
    end_reset();
    edges(11);
    check("t3a_not_yet_halted", {31'd0, halted}, 32'd0);
    edges(1);
    check("t3a_halted", {31'd0, halted}, 32'd1);
    check("t3a_nfetch", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) begin
      check("t3a_fetch1", rd_log[1], 32'h4);
      check("t3a_fetch2", rd_log[2], 32'h10);
      check("t3a_fetch3", rd_log[3], 32'h18);
    end
    check("t3a_r6", dut.u_rf.regs[6], 32'd0);
    check("t3a_pc", pc_dbg, 32'h1C);

    // 3b: not-taken bne falls through
    begin_reset();
    mem[0] = enc_i(6'h08, 0, 1, 16'd5);
    mem[1] = enc_i(6'h05, 1, 1, 16'd2);
    mem[2] = enc_i(6'h08, 0, 6, 16'd9);
    mem[3] = HALT_W;
    end_reset();
    edges(12);
    check("t3b_not_yet_halted", {31'd0, halted}, 32'd0);
    edges(1);
    check("t3b_halted", {31'd0, halted}, 32'd1);
    check("t3b_nfetch", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) check("t3b_fetch2", rd_log[2], 32'h8);
    check("t3b_r6", dut.u_rf.regs[6], 32'd9);

    // 4: R-type ops and R0 behaviour
    begin_reset();
    mem[0] = enc_i(6'h08, 0, 1, 16'd5);
    mem[1] = enc_i(6'h08, 0, 2, 16'd7);
    mem[2] = enc_r(1, 2, 0, 6'h20);
    mem[3] = enc_r(0, 1, 5, 6'h22);
    mem[4] = enc_r(5, 1, 7, 6'h2A);
    mem[5] = enc_r(1, 5, 10, 6'h2A);
    mem[6] = enc_r(1, 2, 8, 6'h24);
    mem[7] = enc_r(1, 2, 9, 6'h25);
    mem[8] = enc_i(6'h08, 0, 11, 16'hFFFD);
    mem[9] = HALT_W;
    end_reset();
    run_to_halt("t4_halt_reached", 200);
    check("t4_r0", dut.u_rf.regs[0], 32'd0);
    check("t4_r5_sub", dut.u_rf.regs[5], 32'hFFFF_FFFB);
    check("t4_r7_slt_neg", dut.u_rf.regs[7], 32'd1);
    check("t4_r10_slt_pos", dut.u_rf.regs[10], 32'd0);
    check("t4_r8_and", dut.u_rf.regs[8], 32'd5);
    check("t4_r9_or", dut.u_rf.regs[9], 32'd7);
    check("t4_r11_addi_neg", dut.u_rf.regs[11], 32'hFFFF_FFFD);

    // 5: signed overflow on add
    begin_reset();
    mem[0]    = enc_i(6'h23, 0, 1, 16'h100);
    mem[1]    = enc_r(1, 1, 1, 6'h20);
    mem[2]    = HALT_W;
    mem[32]   = HALT_W;
    mem[64]   = 32'h7FFF_FFFF;
    end_reset();
    edges(11);
    check("t5_halted", {31'd0, halted}, 32'd1);
`ifdef OVERFLOW_TRAP_EN
    check("t5_r1_kept", dut.u_rf.regs[1], 32'h7FFF_FFFF);
    check("t5_pc_trap", pc_dbg, 32'h84);
`else
    check("t5_r1_wrap", dut.u_rf.regs[1], 32'hFFFF_FFFE);
    check("t5_pc", pc_dbg, 32'hC);
`endif

    // 6: illegal opcode and illegal funct
    begin_reset();
    mem[0] = {6'h3E, 26'd0};
    end_reset();
    edges(2);
    check("t6_op_halted", {31'd0, halted}, 32'd1);
    check("t6_op_illegal", {31'd0, illegal}, 32'd1);
    edges(3);
    check("t6_op_no_req", {31'd0, mem_req}, 32'd0);
    check("t6_op_pc_frozen", pc_dbg, 32'h4);

    begin_reset();
    mem[0] = enc_r(1, 2, 3, 6'h21);
    end_reset();
    edges(2);
    check("t6_fn_halted", {31'd0, halted}, 32'd1);
    check("t6_fn_illegal", {31'd0, illegal}, 32'd1);

    // Reset while a fetch is stalled
    begin_reset();
    mem[0] = enc_i(6'h08, 0, 1, 16'd5);
    mem[1] = enc_i(6'h08, 0, 2, 16'd7);
    end_reset();
    edges(4);
    wait_n = 100;
    edges(1);
    check("rr_pending_req", {31'd0, mem_req}, 32'd1);
    check("rr_pending_ready", {31'd0, mem_ready}, 32'd0);
    check("rr_pending_pc", pc_dbg, 32'h4);
    check("rr_r1_before", dut.u_rf.regs[1], 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("rr_req_dropped", {31'd0, mem_req}, 32'd0);
    check("rr_pc_reset", pc_dbg, 32'h0);
    check("rr_r1_cleared", dut.u_rf.regs[1], 32'd0);
    check("rr_no_write", 32'(wr_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
